// File: rtl/sfu_psum_acc_sequencer.sv
// SFU output-accumulation sequencer: walks 9x36 psums, folds hits into a 16 x COL accumulator buffer.
// Optional build macro SFU_RELU_EN applies per-lane ReLU on the readout path only.
module sfu_psum_acc_sequencer #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   mem_ren,
    output logic [8:0]             mem_addr,
    input  logic [COL*PSUM_BW-1:0] mem_rdata,
    input  logic                   out_rd,
    input  logic [3:0]             out_addr,
    output logic [COL*PSUM_BW-1:0] out_data
);
    // state   | meaning
    // S_IDLE  | waiting for start, readout allowed
    // S_CLEAR | zero accumulators, issue address 0
    // S_RUN   | one psum read per cycle, 324 total
    // S_DRAIN | last read returns and accumulates
    // S_DONE  | done pulse
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                 state;
    logic [5:0]             nij;
    logic [3:0]             kij;
    logic [8:0]             rem;
    logic                   iss_hit;
    logic [3:0]             iss_oaddr;
    logic                   acc_en;
    logic [3:0]             acc_oaddr;
    logic [COL*PSUM_BW-1:0] acc [16];

    logic [2:0]        row, col;
    logic [1:0]        krow, kcol;
    logic signed [3:0] o_row, o_col;
    logic              map_hit;
    logic [3:0]        map_oaddr;

    always_comb begin
        row       = 3'(nij / 6'd6);
        col       = 3'(nij % 6'd6);
        krow      = 2'(kij / 4'd3);
        kcol      = 2'(kij % 4'd3);
        o_row     = $signed({1'b0, row}) - $signed({2'b00, krow});
        o_col     = $signed({1'b0, col}) - $signed({2'b00, kcol});
        map_hit   = (o_row >= 4'sd0) && (o_row <= 4'sd3) && (o_col >= 4'sd0) && (o_col <= 4'sd3);
        map_oaddr = {o_row[1:0], o_col[1:0]};
    end

    function automatic logic [COL*PSUM_BW-1:0] read_word(input logic [COL*PSUM_BW-1:0] w);
        read_word = w;
`ifdef SFU_RELU_EN
        for (int i = 0; i < COL; i++) begin
            if (w[i*PSUM_BW + PSUM_BW-1]) read_word[i*PSUM_BW +: PSUM_BW] = '0;
        end
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_ren   <= 1'b0;
            mem_addr  <= '0;
            nij       <= '0;
            kij       <= '0;
            rem       <= '0;
            iss_hit   <= 1'b0;
            iss_oaddr <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_CLEAR;
                        busy  <= 1'b1;
                        nij   <= '0;
                        kij   <= '0;
                    end
                end
                S_CLEAR, S_RUN: begin
                    // rem counts issues still owed after this one; issue stops at terminal count
                    if (state == S_CLEAR || rem != 9'd0) begin
                        state     <= S_RUN;
                        mem_ren   <= 1'b1;
                        mem_addr  <= (state == S_CLEAR) ? 9'd0 : mem_addr + 9'd1;
                        rem       <= (state == S_CLEAR) ? 9'd323 : rem - 9'd1;
                        iss_hit   <= map_hit;
                        iss_oaddr <= map_oaddr;
                        if (nij == 6'd35) begin
                            nij <= '0;
                            kij <= kij + 4'd1;
                        end else begin
                            nij <= nij + 6'd1;
                        end
                    end else begin
                        state   <= S_DRAIN;
                        mem_ren <= 1'b0;
                        iss_hit <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_en    <= 1'b0;
            acc_oaddr <= '0;
            out_data  <= '0;
            for (int e = 0; e < 16; e++) acc[e] <= '0;
        end else begin
            acc_en    <= mem_ren & iss_hit;
            acc_oaddr <= iss_oaddr;
            if (state == S_CLEAR) begin
                for (int e = 0; e < 16; e++) acc[e] <= '0;
            end else if (acc_en) begin
                for (int i = 0; i < COL; i++) begin
                    acc[acc_oaddr][i*PSUM_BW +: PSUM_BW] <=
                        acc[acc_oaddr][i*PSUM_BW +: PSUM_BW] + mem_rdata[i*PSUM_BW +: PSUM_BW];
                end
            end
            if (out_rd && !busy) out_data <= read_word(acc[out_addr]);
        end
    end
endmodule

// File: tb/tb_sfu_psum_acc_sequencer.sv
// Directed bench for sfu_psum_acc_sequencer: pass timing, accumulation results, abort and readout corners.
module tb_sfu_psum_acc_sequencer;
    localparam int COL = 8;
    localparam int PSUM_BW = 16;
    localparam int W = COL*PSUM_BW;

    logic         clk = 1'b0;
    logic         reset, start, busy, done, mem_ren, out_rd;
    logic [8:0]   mem_addr;
    logic [W-1:0] mem_rdata = '0;
    logic [3:0]   out_addr;
    logic [W-1:0] out_data;
    int           mem_mode = 0;
    int           total = 0;
    int           bad = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] lane0;
    } rd_vec_t;
    rd_vec_t vecs [8];

`ifdef SFU_RELU_EN
    localparam logic [15:0] NEG_EXP = 16'd0;
`else
    localparam logic [15:0] NEG_EXP = 16'hFFD3;
`endif

    sfu_psum_acc_sequencer #(.COL(COL), .PSUM_BW(PSUM_BW)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_rd(out_rd), .out_addr(out_addr), .out_data(out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_ren) begin
            case (mem_mode)
                0:       mem_rdata <= {COL{16'd1}};
                1:       mem_rdata <= W'(mem_addr);
                default: mem_rdata <= {COL{16'hFFFB}};
            endcase
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic read_entry(input logic [3:0] a, output logic [W-1:0] d);
        @(negedge clk);
        out_rd = 1'b1;
        out_addr = a;
        @(posedge clk);
        #1;
        out_rd = 1'b0;
        d = out_data;
    endtask

    task automatic check_all(input string tag, input logic [15:0] lane_val);
        logic [W-1:0] d;
        for (int e = 0; e < 16; e++) begin
            read_entry(4'(e), d);
            check($sformatf("%s_e%0d", tag, e), d, {COL{lane_val}});
        end
    endtask

    // start at c0; optional start/out_rd/reset pokes at given cycles of the pass
    task automatic run_pass(input int mode_i, input logic rd0, input logic [W-1:0] exp_rd0,
                            input int start_at, input int rd_at, input int rst_at);
        int done_cyc, done_cnt, ren_cnt, addr_err, busy_err, ren_err;
        logic [W-1:0] od_before;
        mem_mode = mode_i;
        done_cyc = -1; done_cnt = 0; ren_cnt = 0; addr_err = 0; busy_err = 0; ren_err = 0;
        @(negedge clk);
        start = 1'b1;
        out_rd = rd0;
        out_addr = 4'd15;
        @(posedge clk);
        #1;
        start = 1'b0;
        out_rd = 1'b0;
        if (rd0) check("rd_with_start", out_data, exp_rd0);
        od_before = out_data;
        for (int cyc = 1; cyc <= 340; cyc++) begin
            if (rst_at > 0 && cyc == rst_at + 1) begin
                reset = 1'b0;
                check("abort_busy", W'(busy), W'(0));
                check("abort_ren", W'(mem_ren), W'(0));
                break;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (mem_ren) begin
                if (mem_addr != 9'(ren_cnt)) addr_err++;
                ren_cnt++;
            end
            if (busy != (cyc >= 1 && cyc <= 326)) busy_err++;
            if (mem_ren != (cyc >= 2 && cyc <= 325)) ren_err++;
            start = (cyc == start_at);
            out_rd = (cyc == rd_at);
            if (cyc == rd_at) out_addr = 4'd3;
            if (cyc == rst_at) reset = 1'b1;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        out_rd = 1'b0;
        if (rst_at > 0) begin
            for (int k = 0; k < 6; k++) begin
                if (done) done_cnt++;
                @(posedge clk);
                #1;
            end
            check("abort_no_done", W'(done_cnt), W'(0));
        end else begin
            check("done_cycle", W'(done_cyc), W'(327));
            check("done_pulses", W'(done_cnt), W'(1));
            check("ren_count", W'(ren_cnt), W'(324));
            check("addr_order_err", W'(addr_err), W'(0));
            check("busy_window_err", W'(busy_err), W'(0));
            check("ren_window_err", W'(ren_err), W'(0));
            if (rd_at > 0) check("rd_while_busy_hold", out_data, od_before);
        end
    endtask

    initial begin
        logic [W-1:0] d;
        vecs[0] = '{4'd0,  16'd1359};
        vecs[1] = '{4'd1,  16'd1368};
        vecs[2] = '{4'd3,  16'd1386};
        vecs[3] = '{4'd4,  16'd1413};
        vecs[4] = '{4'd5,  16'd1422};
        vecs[5] = '{4'd10, 16'd1485};
        vecs[6] = '{4'd12, 16'd1521};
        vecs[7] = '{4'd15, 16'd1548};

        reset = 1'b1; start = 1'b0; out_rd = 1'b0; out_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_ren", W'(mem_ren), W'(0));
        check("rst_addr", W'(mem_addr), W'(0));
        check("rst_out_data", out_data, '0);
        @(negedge clk);
        reset = 1'b0;
        read_entry(4'd5, d);
        check("rst_acc_e5", d, '0);

        run_pass(0, 1'b0, '0, -1, -1, -1);
        check_all("all9", 16'd9);

        run_pass(1, 1'b0, '0, -1, -1, -1);
        foreach (vecs[v]) begin
            read_entry(vecs[v].addr, d);
            check($sformatf("ramp_e%0d", vecs[v].addr), d, W'(vecs[v].lane0));
        end

        run_pass(2, 1'b1, W'(16'd1548), -1, -1, -1);
        check_all("neg5", NEG_EXP);

        run_pass(0, 1'b0, '0, 50, 60, -1);
        check_all("restart_ign", 16'd9);

        run_pass(2, 1'b0, '0, -1, -1, 100);
        check_all("abort_zero", 16'd0);
        run_pass(0, 1'b0, '0, -1, -1, -1);
        check_all("post_abort", 16'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
